// File: rtl/pipe_hazard_if.sv
// Pipeline-side view of the hazard controller: stage fields in, register
// stall/bubble controls, run status and performance counters out.
interface pipe_hazard_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       M_icode;
  logic [3:0]       m_stat;
  logic [3:0]       W_icode;
  logic [3:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic             halted;
  logic [3:0]       cpu_stat;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // pipeline datapath side
  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_icode, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, halted, cpu_stat, cyc_cnt, ret_cnt, stall_cnt
  );

  // control unit side
  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_icode, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, halted, cpu_stat, cyc_cnt, ret_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 five-stage pipeline control: stall/bubble generation for
// load/use, ret and mispredict hazards, exception draining into a
// frozen HALTED state, and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int         CNT_W = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_hazard_if.slave bus
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic set_cc;
  } ctrl_t;

  function automatic logic exc(input logic [3:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   loaduse, retp, misp, m_exc, w_exc;
  logic   to_halt;

  // hazard detection terms from the current stage contents
  always_comb begin
    loaduse = ((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) &&
              (bus.E_dstM != RNONE) &&
              ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    retp    = (bus.D_icode == IRET) || (bus.E_icode == IRET) ||
              (bus.M_icode == IRET);
    misp    = (bus.E_icode == IJXX) && !bus.e_cnd;
    m_exc   = exc(bus.m_stat);
    w_exc   = exc(bus.W_stat);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // next state; a writeback exception always wins over a memory one
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (w_exc)      state_nxt = HALTED;
        else if (m_exc) state_nxt = DRAIN;
      end
      DRAIN:   if (w_exc) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  assign to_halt = (state != HALTED) && (state_nxt == HALTED);

  // stall/bubble controls; reset flushes nops, HALTED freezes everything
  always_comb begin
    ctrl = '0;
    if (!rst_n) begin
      ctrl.d_bubble = 1'b1;
      ctrl.e_bubble = 1'b1;
      ctrl.m_bubble = 1'b1;
    end else if (state == HALTED) begin
      ctrl.f_stall  = 1'b1;
      ctrl.d_stall  = 1'b1;
      ctrl.w_stall  = 1'b1;
      ctrl.e_bubble = 1'b1;
      ctrl.m_bubble = 1'b1;
    end else begin
      ctrl.f_stall  = loaduse | retp;
      ctrl.d_stall  = loaduse;
      ctrl.d_bubble = misp | (retp & !loaduse);
      ctrl.e_bubble = misp | loaduse;
      ctrl.m_bubble = m_exc | w_exc;
      ctrl.w_stall  = w_exc;
      ctrl.set_cc   = (bus.E_icode == IOPQ) & !m_exc & !w_exc;
    end
  end

  assign bus.F_stall  = ctrl.f_stall;
  assign bus.D_stall  = ctrl.d_stall;
  assign bus.D_bubble = ctrl.d_bubble;
  assign bus.E_bubble = ctrl.e_bubble;
  assign bus.M_bubble = ctrl.m_bubble;
  assign bus.W_stall  = ctrl.w_stall;
  assign bus.set_cc   = ctrl.set_cc;

  // architectural status captured from writeback on the halting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.halted   <= 1'b0;
      bus.cpu_stat <= SAOK;
    end else if (to_halt) begin
      bus.halted   <= 1'b1;
      bus.cpu_stat <= bus.W_stat;
    end
  end

  // saturating performance counters, all frozen once halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cyc_cnt   <= '0;
      bus.ret_cnt   <= '0;
      bus.stall_cnt <= '0;
    end else if (state != HALTED) begin
      if (bus.cyc_cnt != '1)
        bus.cyc_cnt <= bus.cyc_cnt + ONE;
      if ((bus.W_stat == SAOK) && (bus.W_icode != INOP) && (bus.ret_cnt != '1))
        bus.ret_cnt <= bus.ret_cnt + ONE;
      if ((ctrl.f_stall | ctrl.e_bubble) && (bus.stall_cnt != '1))
        bus.stall_cnt <= bus.stall_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard controls, drain/halt
// sequencing, async reset and counter saturation (CNT_W=4).
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.CNT_W(CW), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // packed view of controls: F D Db Eb Mb W cc
  logic [6:0] ctl;
  assign ctl = {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                bus.M_bubble, bus.W_stall, bus.set_cc};

  task automatic idle();
    bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd = 1'b0;
    bus.M_icode = 4'h1; bus.m_stat = 4'h1;
    bus.W_icode = 4'h1; bus.W_stat = 4'h1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; idle();
    #1;
    checks++; if (ctl !== 7'b0011100) begin errors++; $display("FAIL reset_ctl got %b exp 0011100", ctl); end
    @(negedge clk);
    checks++; if (bus.halted !== 1'b0 || bus.cpu_stat !== 4'h1) begin errors++; $display("FAIL reset_stat got %0d/%0h exp 0/1", bus.halted, bus.cpu_stat); end
    checks++; if ({bus.cyc_cnt, bus.ret_cnt, bus.stall_cnt} !== 12'h0) begin errors++; $display("FAIL reset_cnt got %h exp 000", {bus.cyc_cnt, bus.ret_cnt, bus.stall_cnt}); end
    rst_n = 1'b1; #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL idle_ctl got %b exp 0000000", ctl); end
  endtask

  task automatic test_loaduse();
    do_reset();
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3; #1;
    checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL loaduse got %b exp 1101000", ctl); end
    bus.E_dstM = 4'hF; bus.d_srcB = 4'hF; #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL loaduse_rnone got %b exp 0000000", ctl); end
    bus.E_icode = 4'hB; bus.E_dstM = 4'h7; bus.d_srcA = 4'h2; bus.d_srcB = 4'h7; #1;
    checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL loaduse_popq_srcB got %b exp 1101000", ctl); end
    idle();
  endtask

  task automatic test_ret();
    do_reset();
    bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL ret got %b exp 1010000", ctl); end
    bus.D_icode = 4'h1; bus.M_icode = 4'h9; #1;
    checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL ret_m got %b exp 1010000", ctl); end
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3; #1;
    checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL ret_loaduse got %b exp 1101000", ctl); end
    idle();
  endtask

  task automatic test_misp();
    do_reset();
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0; #1;
    checks++; if (ctl !== 7'b0011000) begin errors++; $display("FAIL misp got %b exp 0011000", ctl); end
    bus.e_cnd = 1'b1; #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL jmp_taken got %b exp 0000000", ctl); end
    bus.E_icode = 4'h6; #1;
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL opq_setcc got %b exp 0000001", ctl); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    repeat (3) @(negedge clk);
    checks++; if (bus.stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt_lu got %0d exp 3", bus.stall_cnt); end
    idle(); bus.E_icode = 4'h7;
    repeat (2) @(negedge clk);
    idle();
    @(negedge clk);
    checks++; if (bus.stall_cnt !== 4'd5) begin errors++; $display("FAIL stall_cnt_misp got %0d exp 5", bus.stall_cnt); end
    checks++; if (bus.cyc_cnt !== 4'd6) begin errors++; $display("FAIL cyc_cnt_b2b got %0d exp 6", bus.cyc_cnt); end
  endtask

  task automatic test_drain();
    logic [CW-1:0] cyc_frz, stl_frz;
    do_reset();
    bus.m_stat = 4'h3; bus.E_icode = 4'h6; #1;
    checks++; if (ctl !== 7'b0000100) begin errors++; $display("FAIL drain_m got %b exp 0000100", ctl); end
    @(negedge clk);
    bus.m_stat = 4'h1; bus.W_stat = 4'h3; #1;
    checks++; if (ctl !== 7'b0000110 || bus.halted !== 1'b0) begin errors++; $display("FAIL drain_w got %b/%0d exp 0000110/0", ctl, bus.halted); end
    @(negedge clk);
    checks++; if (bus.halted !== 1'b1 || bus.cpu_stat !== 4'h3) begin errors++; $display("FAIL drain_halt got %0d/%0h exp 1/3", bus.halted, bus.cpu_stat); end
    checks++; if (ctl !== 7'b1101110) begin errors++; $display("FAIL halted_ctl got %b exp 1101110", ctl); end
    checks++; if (bus.cyc_cnt !== 4'd2) begin errors++; $display("FAIL drain_cyc got %0d exp 2", bus.cyc_cnt); end
    cyc_frz = bus.cyc_cnt; stl_frz = bus.stall_cnt;
    idle(); bus.W_icode = 4'h6;
    repeat (3) @(negedge clk);
    checks++; if (bus.cyc_cnt !== cyc_frz || bus.stall_cnt !== stl_frz || bus.ret_cnt !== 4'd0) begin errors++; $display("FAIL halted_frozen got %0d/%0d/%0d exp %0d/%0d/0", bus.cyc_cnt, bus.stall_cnt, bus.ret_cnt, cyc_frz, stl_frz); end
    checks++; if (bus.halted !== 1'b1 || ctl !== 7'b1101110) begin errors++; $display("FAIL halted_terminal got %0d/%b exp 1/1101110", bus.halted, ctl); end
    idle();
  endtask

  task automatic test_simul();
    do_reset();
    bus.m_stat = 4'h4; bus.W_stat = 4'h2;
    @(negedge clk);
    checks++; if (bus.halted !== 1'b1 || bus.cpu_stat !== 4'h2) begin errors++; $display("FAIL simul_halt got %0d/%0h exp 1/2", bus.halted, bus.cpu_stat); end
    rst_n = 1'b0; idle(); #1;
    checks++; if (bus.halted !== 1'b0 || bus.cpu_stat !== 4'h1 || bus.cyc_cnt !== 4'd0) begin errors++; $display("FAIL async_rst got %0d/%0h/%0d exp 0/1/0", bus.halted, bus.cpu_stat, bus.cyc_cnt); end
    checks++; if (ctl !== 7'b0011100) begin errors++; $display("FAIL async_rst_ctl got %b exp 0011100", ctl); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.halted !== 1'b0 || bus.cyc_cnt !== 4'd1) begin errors++; $display("FAIL post_rst_run got %0d/%0d exp 0/1", bus.halted, bus.cyc_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.W_icode = 4'h6;
    repeat (5) @(negedge clk);
    checks++; if (bus.ret_cnt !== 4'd5 || bus.cyc_cnt !== 4'd5) begin errors++; $display("FAIL cnt_5 got %0d/%0d exp 5/5", bus.ret_cnt, bus.cyc_cnt); end
    repeat (15) @(negedge clk);
    checks++; if (bus.ret_cnt !== 4'd15 || bus.cyc_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d/%0d exp 15/15", bus.ret_cnt, bus.cyc_cnt); end
    checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL stall_idle got %0d exp 0", bus.stall_cnt); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_loaduse();
    test_ret();
    test_misp();
    test_back_to_back();
    test_drain();
    test_simul();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 pipeline. It computes per-cycle stall and bubble controls for the F/D/E/M/W pipeline registers, covering load/use hazards, ret handling, mispredicted jumps and exception draining. It also holds the processor run state (RUN/DRAIN/HALTED) and performance counters. It sits beside the pipeline registers and drives their stall/bubble inputs.

Parameters:
CNT_W, 32, width of each performance counter (saturating)
RNONE, 4'hF, register ID meaning "no register"

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
D_icode  in  4  icode in decode register
d_srcA  in  4  decode srcA
d_srcB  in  4  decode srcB
E_icode  in  4  icode in execute register
E_dstM  in  4  execute dstM
e_cnd  in  1  branch condition from execute
M_icode  in  4  icode in memory register
m_stat  in  4  status produced by memory stage
W_icode  in  4  icode in writeback register
W_stat  in  4  status in writeback register
F_stall  out  1  hold fetch PC register
D_stall  out  1  hold decode register
D_bubble  out  1  load nop into decode register
E_bubble  out  1  load nop into execute register
M_bubble  out  1  load nop into memory register
W_stall  out  1  hold writeback register
set_cc  out  1  permit condition-code update
halted  out  1  processor stopped
cpu_stat  out  4  architectural status (AOK=1, HLT=2, ADR=3, INS=4)
cyc_cnt  out  CNT_W  cycles spent in RUN or DRAIN
ret_cnt  out  CNT_W  retired instructions
stall_cnt  out  CNT_W  cycles with F_stall or E_bubble asserted

Behaviour:
- Encodings: IHALT=0, INOP=1, IOPQ=6, IJXX=7, IRET=9, IMRMOVQ=5, IPOPQ=B. "exc(s)" means s ∈ {HLT, ADR, INS}.
- The control outputs are combinational from inputs and state. Counters, halted and cpu_stat are registered.
- Hazard terms:
  - loaduse = E_icode ∈ {IMRMOVQ, IPOPQ} && E_dstM != RNONE && (E_dstM == d_srcA || E_dstM == d_srcB).
  - retp = IRET ∈ {D_icode, E_icode, M_icode}.
  - misp = E_icode == IJXX && !e_cnd.
- RUN/DRAIN control outputs:
  - F_stall = loaduse | retp.
  - D_stall = loaduse.
  - D_bubble = misp | (retp & !loaduse).
  - E_bubble = misp | loaduse.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
  - set_cc = (E_icode == IOPQ) & !exc(m_stat) & !exc(W_stat).
- D_stall and D_bubble are never both 1. Loaduse has priority over retp.
- State machine:
  - RUN → DRAIN when exc(m_stat) && !exc(W_stat).
  - RUN → HALTED when exc(W_stat).
  - DRAIN → HALTED when exc(W_stat).
  - HALTED is terminal until reset.
- Status and halted:
  - On entering HALTED, cpu_stat <= W_stat and halted <= 1 in the same edge.
  - If exc(m_stat) and exc(W_stat) occur together, W_stat wins and the state goes directly to HALTED.
- HALTED outputs: F_stall=1, D_stall=1, W_stall=1, E_bubble=1, M_bubble=1, D_bubble=0, set_cc=0. The pipeline is frozen.
- Counters:
  - cyc_cnt increments every cycle in RUN or DRAIN.
  - ret_cnt increments when W_stat == AOK && W_icode != INOP && state != HALTED.
  - stall_cnt increments when (F_stall | E_bubble) && state != HALTED.
  - All counters saturate at all-ones and never wrap.
- Reset (rst_n low, async):
  - state=RUN, halted=0, cpu_stat=AOK, all counters=0.
  - While rst_n is low, force D_bubble=E_bubble=M_bubble=1, F_stall=D_stall=W_stall=0, set_cc=0, so nops flush through.
  - Reset asserted mid-DRAIN or in HALTED returns to RUN immediately.
- First edge after rst_n deasserts: normal RUN evaluation.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Same stimulus with E_dstM=F, d_srcB=F -> all control outputs 0.
- Ret, then load/use plus ret: D_icode=9, no loaduse -> F_stall=1, D_bubble=1, D_stall=0. Add loaduse -> D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1. With e_cnd=1 -> both 0. With E_icode=6 -> set_cc=1.
- Exception drain: m_stat=ADR for one cycle -> M_bubble=1, set_cc=0, state DRAIN. Next cycle W_stat=ADR -> W_stall=1, then halted=1, cpu_stat=3, cyc_cnt frozen.
- Simultaneous m_stat=INS and W_stat=HLT -> direct HALTED with cpu_stat=2. Pulse rst_n low -> halted=0, cpu_stat=1, counters 0.
- Counter saturation with CNT_W=4: run 20 cycles with W_icode=6, W_stat=AOK -> ret_cnt=15, cyc_cnt=15, no wrap.
